// File: rtl/igmp_query_rx.sv
`default_nettype none
// ============================================================================
// Module   : igmp_query_rx
// Purpose  : Parses the MAC RX word stream for IGMP Membership Queries that
//            are general or aimed at our group. Each accepted query arms a
//            pseudo-random response delay, bounded by Max Resp Code. When the
//            delay expires a report request is raised for the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module igmp_query_rx #(
  parameter logic [31:0] GROUP_IP    = 32'hE001_0104,
  parameter int unsigned TICK_CYCLES = 12500000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Mac_rx_data,
  input  logic [1:0]  Mac_rx_mod,
  input  logic        Mac_rx_sop,
  input  logic        Mac_rx_eop,
  input  logic        Mac_rx_valid,
  input  logic        report_ack,
  output logic        report_req,
  output logic        query_seen,
  output logic [15:0] query_cnt
);

  localparam logic [31:0] c_all_hosts = 32'hE000_0001;
  localparam int          c_presc_w   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {P_IDLE, P_PARSE, P_DROP} pstate_t;
  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_REQ}   tstate_t;

  pstate_t              r_pstate;
  tstate_t              r_tstate;
  logic [4:0]           r_wcnt;
  logic [3:0]           r_ihl;
  logic                 r_dst_grp;
  logic [7:0]           r_maxresp;
  logic [15:0]          r_lfsr;
  logic [7:0]           r_ticks;
  logic [c_presc_w-1:0] r_presc;

  logic       w_word;      // valid, non-sop word while parsing
  logic [4:0] w_b;         // index of the IGMP header word
  logic       w_group_ok;
  logic       w_fail;
  logic       w_accept;
  logic [6:0] w_m;
  logic [14:0] w_prod;
  logic [7:0] w_delay;
  logic       w_unused;

  // Mod bits carry no information the parser needs.
  assign w_unused = ^Mac_rx_mod;

  // Header field checks against the word currently on the bus.
  always_comb begin
    w_word     = Mac_rx_valid && !Mac_rx_sop && (r_pstate == P_PARSE);
    w_b        = 5'd4 + {1'b0, r_ihl};
    w_group_ok = (Mac_rx_data == 32'h0) ||
                 ((Mac_rx_data == GROUP_IP) && r_dst_grp);
    w_fail     = 1'b0;
    if (r_wcnt == 5'd1 && Mac_rx_data[31:24] != 8'h5E)       w_fail = 1'b1;
    if (r_wcnt == 5'd3 && Mac_rx_data[15:0] != 16'h0800)     w_fail = 1'b1;
    if (r_wcnt == 5'd4 && (Mac_rx_data[31:28] != 4'd4 ||
                           Mac_rx_data[27:24] < 4'd5))       w_fail = 1'b1;
    if (r_wcnt == 5'd6 && Mac_rx_data[23:16] != 8'd2)        w_fail = 1'b1;
    if (r_wcnt == 5'd8 && Mac_rx_data != c_all_hosts &&
        Mac_rx_data != GROUP_IP)                             w_fail = 1'b1;
    if (r_wcnt >= 5'd9 && r_wcnt == w_b &&
        Mac_rx_data[31:24] != 8'h11)                         w_fail = 1'b1;
    if (r_wcnt >= 5'd9 && r_wcnt == w_b + 5'd1 && !w_group_ok) w_fail = 1'b1;
    w_accept = w_word && (r_wcnt >= 5'd9) && (r_wcnt == w_b + 5'd1) && w_group_ok;
  end

  // Response delay: clamp Max Resp Code to 1..127, scale the LFSR byte by it.
  always_comb begin
    if (r_maxresp[7])            w_m = 7'd127;
    else if (r_maxresp == 8'd0)  w_m = 7'd1;
    else                         w_m = r_maxresp[6:0];
    w_prod  = {7'b0, r_lfsr[7:0]} * {8'b0, w_m};
    w_delay = {1'b0, w_prod[14:8]};
  end

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Frame parser, word counter, captured fields and query accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pstate   <= P_IDLE;
      r_wcnt     <= 5'd0;
      r_ihl      <= 4'd0;
      r_dst_grp  <= 1'b0;
      r_maxresp  <= 8'd0;
      query_seen <= 1'b0;
      query_cnt  <= 16'd0;
    end else begin
      query_seen <= w_accept;
      if (w_accept) query_cnt <= query_cnt + 16'd1;
      if (Mac_rx_valid) begin
        if (Mac_rx_sop)              r_wcnt <= 5'd1;
        else if (r_wcnt != 5'd31)    r_wcnt <= r_wcnt + 5'd1;

        if (Mac_rx_sop) begin
          // A sop always restarts parsing, whatever state we were in.
          if (Mac_rx_eop)                          r_pstate <= P_IDLE;
          else if (Mac_rx_data[15:0] == 16'h0100)  r_pstate <= P_PARSE;
          else                                     r_pstate <= P_DROP;
        end else begin
          case (r_pstate)
            P_PARSE: begin
              if (w_accept)       r_pstate <= Mac_rx_eop ? P_IDLE : P_DROP;
              else if (Mac_rx_eop) r_pstate <= P_IDLE;
              else if (w_fail)    r_pstate <= P_DROP;
            end
            P_DROP:  if (Mac_rx_eop) r_pstate <= P_IDLE;
            default: r_pstate <= r_pstate;
          endcase
        end

        if (w_word) begin
          if (r_wcnt == 5'd4) r_ihl     <= Mac_rx_data[27:24];
          if (r_wcnt == 5'd8) r_dst_grp <= (Mac_rx_data == GROUP_IP);
          if (r_wcnt >= 5'd9 && r_wcnt == w_b) r_maxresp <= Mac_rx_data[23:16];
        end
      end
    end
  end

  // Response timer: countdown in prescaled ticks, then hold the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tstate   <= T_IDLE;
      r_ticks    <= 8'd0;
      r_presc    <= '0;
      report_req <= 1'b0;
    end else begin
      case (r_tstate)
        T_IDLE: begin
          if (w_accept) begin
            r_ticks <= w_delay;
            r_presc <= '0;
            if (w_delay == 8'd0) begin
              r_tstate   <= T_REQ;
              report_req <= 1'b1;
            end else begin
              r_tstate <= T_WAIT;
            end
          end
        end
        T_WAIT: begin
          if (w_accept && (w_delay < r_ticks)) begin
            // A sooner deadline replaces the pending one.
            r_ticks <= w_delay;
            r_presc <= '0;
            if (w_delay == 8'd0) begin
              r_tstate   <= T_REQ;
              report_req <= 1'b1;
            end
          end else if (r_presc == c_presc_max) begin
            r_presc <= '0;
            r_ticks <= r_ticks - 8'd1;
            if (r_ticks == 8'd1) begin
              r_tstate   <= T_REQ;
              report_req <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        T_REQ: begin
          if (report_ack) begin
            r_tstate   <= T_IDLE;
            report_req <= 1'b0;
          end
        end
        default: begin
          r_tstate   <= T_IDLE;
          report_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_igmp_query_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_igmp_query_rx
// Purpose  : Directed frames into igmp_query_rx, checked every cycle against
//            a deadline-based behavioural model of the query responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_igmp_query_rx;

  localparam logic [31:0] GROUP = 32'hE001_0104;
  localparam logic [31:0] ALLH  = 32'hE000_0001;
  localparam int          TICKS = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [1:0]  mod = '0;
  logic        sop = 1'b0, eop = 1'b0, valid = 1'b0, ack = 1'b0;
  logic        report_req, query_seen;
  logic [15:0] query_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  igmp_query_rx #(.GROUP_IP(GROUP), .TICK_CYCLES(TICKS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .Mac_rx_data(data), .Mac_rx_mod(mod),
    .Mac_rx_sop(sop), .Mac_rx_eop(eop), .Mac_rx_valid(valid),
    .report_ack(ack), .report_req(report_req), .query_seen(query_seen),
    .query_cnt(query_cnt)
  );

  // ---------------- behavioural model ----------------
  bit          m_acc = 1'b0;  // driver marks the cycle a query completes
  logic [7:0]  m_mr  = '0;
  logic [15:0] m_lfsr;
  bit          m_wait, m_req, m_seen;
  logic [15:0] m_cnt;
  longint      m_now, m_deadline;
  int          m_d, m_rem;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int delay_of(input logic [7:0] rnd, input logic [7:0] mr);
    int m;
    m = (mr >= 8'd128) ? 127 : ((mr == 8'd0) ? 1 : int'(mr));
    return (int'(rnd) * m) / 256;
  endfunction

  // Deadline form of the responder: request due TICKS*D edges after accept.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = SEED; m_wait = 0; m_req = 0; m_seen = 0; m_cnt = 0;
      m_now = 0; m_deadline = 0;
    end else begin
      m_now++;
      m_seen = m_acc;
      if (m_acc) m_cnt++;
      if (m_req) begin
        if (ack) m_req = 0;
      end else if (m_acc) begin
        m_d = delay_of(m_lfsr[7:0], m_mr);
        if (!m_wait) begin
          m_wait = 1; m_deadline = m_now + TICKS * m_d;
        end else begin
          m_rem = int'((m_deadline - m_now + TICKS) / TICKS);
          if (m_d < m_rem) m_deadline = m_now + TICKS * m_d;
        end
      end
      if (m_wait && m_now >= m_deadline) begin
        m_wait = 0; m_req = 1;
      end
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 3;
      if (report_req !== m_req) begin
        errors++; $display("FAIL cyc report_req @%0t: got %b want %b", $time, report_req, m_req);
      end
      if (query_seen !== m_seen) begin
        errors++; $display("FAIL cyc query_seen @%0t: got %b want %b", $time, query_seen, m_seen);
      end
      if (query_cnt !== m_cnt) begin
        errors++; $display("FAIL cyc query_cnt @%0t: got %0h want %0h", $time, query_cnt, m_cnt);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- frame construction ----------------
  logic [31:0] fw [24];
  int fn;

  task automatic build(input int ihl, input logic [31:0] dst, input logic [31:0] grp,
                       input logic [7:0] typ, input logic [7:0] mr, input logic [7:0] proto);
    int b;
    b = 4 + ihl;
    for (int i = 0; i < 24; i++) fw[i] = 32'h0;
    fw[0] = 32'h0000_0100;
    fw[1] = 32'h5E00_0001;
    fw[2] = 32'h0002_0304;
    fw[3] = 32'h0506_0800;
    fw[4] = {4'h4, 4'(ihl), 8'h00, 16'(4 * ihl + 12)};
    fw[5] = 32'h1234_0000;
    fw[6] = {8'h01, proto, 16'hBEEF};
    fw[7] = 32'hC0A8_0001;
    fw[8] = dst;
    for (int i = 9; i < b; i++) fw[i] = 32'h9404_0000;
    fw[b]     = {typ, mr, 16'hEE00};
    fw[b + 1] = grp;
    fw[b + 2] = 32'h0;
    fn = b + 3;
  endtask

  // Acceptance rules applied to a whole frame of n words.
  function automatic int model_parse(input int n, output logic [7:0] mr);
    int ihl, b;
    mr  = 8'h0;
    ihl = int'(fw[4][27:24]);
    b   = 4 + ihl;
    if (n < b + 2) return -1;
    if (fw[0][15:0] != 16'h0100 || fw[1][31:24] != 8'h5E || fw[3][15:0] != 16'h0800) return -1;
    if (fw[4][31:28] != 4'd4 || ihl < 5 || fw[6][23:16] != 8'd2) return -1;
    if (fw[8] != ALLH && fw[8] != GROUP) return -1;
    if (fw[b][31:24] != 8'h11) return -1;
    if (!(fw[b + 1] == 32'h0 || (fw[b + 1] == GROUP && fw[8] == GROUP))) return -1;
    mr = fw[b][23:16];
    return b + 1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // len < 0 sends the whole frame; with_eop marks its last sent word.
  task automatic send(input string name, input int expect_idx, input int len,
                      input bit with_eop, input int bubble_at);
    logic [7:0] mr;
    int acc, n;
    n   = (len < 0) ? fn : len;
    acc = model_parse(n, mr);
    check({name, " accept index"}, 64'(acc), 64'(expect_idx));
    for (int i = 0; i < n; i++) begin
      if (i == bubble_at) begin
        valid = 0; sop = 0; eop = 0; data = 32'hDEAD_BEEF; m_acc = 0;
        tick();
      end
      data  = fw[i];
      sop   = (i == 0);
      eop   = with_eop && (i == n - 1);
      valid = 1;
      m_acc = (i == acc);
      m_mr  = mr;
      tick();
    end
    valid = 0; sop = 0; eop = 0; m_acc = 0; data = 32'h0;
    repeat (2) tick();
  endtask

  task automatic wait_req_and_ack(input string name, input int budget);
    int k;
    k = 0;
    while (report_req !== 1'b1 && k < budget) begin
      tick(); k++;
    end
    check({name, " report_req within budget"}, 64'(report_req), 64'd1);
    if (report_req === 1'b1) begin
      ack = 1; tick(); ack = 0;
      check({name, " report_req dropped after ack"}, 64'(report_req), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pin the model's arithmetic with hand-computed values.
    check("lfsr step from seed", 64'(lfsr_next(16'hACE1)), 64'hE270);
    check("delay ff*100",        64'(delay_of(8'hFF, 8'd100)), 64'd99);
    check("delay ff*200 clamp",  64'(delay_of(8'hFF, 8'd200)), 64'd126);
    check("delay mr0 as 1",      64'(delay_of(8'hFF, 8'd0)),   64'd0);
    check("delay 80*100",        64'(delay_of(8'h80, 8'd100)), 64'd50);

    repeat (3) tick();
    chk_en = 1;
    check("reset report_req", 64'(report_req), 64'd0);
    check("reset query_seen", 64'(query_seen), 64'd0);
    check("reset query_cnt",  64'(query_cnt),  64'd0);
    rst = 0;
    repeat (3) tick();

    // General query, IHL 6, with a bubble inside the frame.
    build(6, ALLH, 32'h0, 8'h11, 8'd100, 8'd2);
    send("general", 11, -1, 1, 5);
    check("cnt after general", 64'(query_cnt), 64'd1);
    wait_req_and_ack("general", 1 + 4 * 99);

    // Group-specific accepted; wrong group and wrong destination rejected.
    build(5, GROUP, GROUP, 8'h11, 8'd10, 8'd2);
    send("group", 10, -1, 1, -1);
    wait_req_and_ack("group", 60);
    build(5, GROUP, 32'hE001_0105, 8'h11, 8'd10, 8'd2);
    send("wrong group", -1, -1, 1, -1);
    build(5, ALLH, GROUP, 8'h11, 8'd10, 8'd2);
    send("group on allhosts", -1, -1, 1, -1);
    repeat (60) tick();
    check("cnt after group tests", 64'(query_cnt), 64'd2);
    check("no req after rejects",  64'(report_req), 64'd0);

    // Non-IGMP and non-query frames ignored; parser recovers afterwards.
    build(5, ALLH, 32'h0, 8'h11, 8'd10, 8'd17);
    send("udp", -1, -1, 1, -1);
    build(5, ALLH, 32'h0, 8'h16, 8'd10, 8'd2);
    send("report type", -1, -1, 1, -1);
    build(5, ALLH, 32'h0, 8'h11, 8'd10, 8'd2);
    send("recover", 10, -1, 1, -1);
    check("cnt after recover", 64'(query_cnt), 64'd3);
    wait_req_and_ack("recover", 60);

    // Long wait shortened to immediate by maxresp 1.
    build(5, ALLH, 32'h0, 8'h11, 8'd100, 8'd2);
    send("long", 10, -1, 1, -1);
    build(5, ALLH, 32'h0, 8'h11, 8'd1, 8'd2);
    send("shorten", 10, -1, 1, -1);
    check("req after shorten", 64'(report_req), 64'd1);
    wait_req_and_ack("shorten", 2);
    // A later query with a larger bound must not push the deadline out.
    build(5, ALLH, 32'h0, 8'h11, 8'd20, 8'd2);
    send("short", 10, -1, 1, -1);
    build(5, ALLH, 32'h0, 8'h11, 8'd127, 8'd2);
    send("larger", 10, -1, 1, -1);
    wait_req_and_ack("larger", 4 * 20 + 4);
    check("cnt after timer tests", 64'(query_cnt), 64'd7);

    // Truncated frame, then a frame cut by sop, then the restarted query.
    build(5, ALLH, 32'h0, 8'h11, 8'd1, 8'd2);
    send("truncated", -1, 9, 1, -1);
    send("cut by sop", -1, 6, 0, -1);
    check("cnt after truncations", 64'(query_cnt), 64'd7);
    send("restarted", 10, -1, 1, -1);
    check("cnt after restart", 64'(query_cnt), 64'd8);
    wait_req_and_ack("restarted", 4);

    // Reset during the wait.
    build(5, ALLH, 32'h0, 8'h11, 8'd127, 8'd2);
    send("pre-reset", 10, -1, 1, -1);
    rst = 1; #1;
    check("rst wait report_req", 64'(report_req), 64'd0);
    check("rst wait query_cnt",  64'(query_cnt),  64'd0);
    tick(); rst = 0;
    repeat (4 * 127 + 10) tick();
    check("no req after rst wait", 64'(report_req), 64'd0);

    // Reset while the request is held.
    build(5, ALLH, 32'h0, 8'h11, 8'd1, 8'd2);
    send("pre-reset req", 10, -1, 1, -1);
    check("req before rst", 64'(report_req), 64'd1);
    rst = 1; #1;
    check("rst req report_req", 64'(report_req), 64'd0);
    check("rst req query_cnt",  64'(query_cnt),  64'd0);
    tick(); rst = 0;
    repeat (40) tick();
    check("no req after rst req", 64'(report_req), 64'd0);
    check("cnt after rst req",    64'(query_cnt),  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
